// File: rtl/hamming74_decoder_if.sv
// -----------------------------------------------------------------------------
// hamming74_decoder_if
//
// Streaming bus between the Hamming(7,4) decoder and its neighbours.
//   in_valid      upstream codeword valid
//   in_ready      decoder can accept a codeword this cycle
//   in_code       7-bit codeword {d3,d2,d1,p4,d0,p2,p1}
//   out_valid     decoded word held in the output register
//   out_ready     downstream accepts the output this cycle
//   out_data      corrected data {d3,d2,d1,d0}
//   out_syndrome  {s4,s2,s1}; 0 = clean, else 1-based error bit position
//   out_corrected syndrome was non-zero
//
// modport slave  : the decoder side
// modport master : the side that drives codewords and consumes results
// -----------------------------------------------------------------------------
interface hamming74_decoder_if;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] in_code;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic [2:0] out_syndrome;
   logic       out_corrected;

   modport slave (
      input  in_valid, in_code, out_ready,
      output in_ready, out_valid, out_data, out_syndrome, out_corrected
   );

   modport master (
      output in_valid, in_code, out_ready,
      input  in_ready, out_valid, out_data, out_syndrome, out_corrected
   );
endinterface

// File: rtl/hamming74_decoder.sv
// -----------------------------------------------------------------------------
// hamming74_decoder
//
// Streaming Hamming(7,4) single-error-correcting decoder with a one-entry
// registered output stage and saturating link statistics.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   bus         hamming74_decoder_if.slave (codeword in, corrected word out)
//   clr_count   synchronous clear of both counters (wins over increments)
//   word_count  codewords accepted since reset/clear, saturating
//   corr_count  accepted codewords with a non-zero syndrome, saturating
//
// The codeword is decoded combinationally from in_code but only ever reaches
// the outputs through the output register, so the sole combinational path is
// out_ready -> in_ready.
// -----------------------------------------------------------------------------
module hamming74_decoder #(
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   hamming74_decoder_if.slave bus,
   input  logic               clr_count,
   output logic [CNT_W-1:0]   word_count,
   output logic [CNT_W-1:0]   corr_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic       accept;
   logic [2:0] syndrome;
   logic [6:0] flip_mask;
   logic [6:0] fixed_code;

   // Single output register: free a slot whenever the held word leaves.
   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      // NOTE: every variable gets a default before any conditional update so
      // no path leaves it unassigned, which would infer a latch.
      flip_mask  = '0;
      syndrome   = {bus.in_code[3] ^ bus.in_code[4] ^ bus.in_code[5] ^ bus.in_code[6],
                    bus.in_code[1] ^ bus.in_code[2] ^ bus.in_code[5] ^ bus.in_code[6],
                    bus.in_code[0] ^ bus.in_code[2] ^ bus.in_code[4] ^ bus.in_code[6]};
      // The syndrome is the 1-based position of the bad bit.
      if (syndrome != 3'd0) begin
         flip_mask = 7'd1 << (syndrome - 3'd1);
      end
      fixed_code = bus.in_code ^ flip_mask;
   end

   // Output register with valid/ready flow control.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         bus.out_valid     <= 1'b0;
         bus.out_data      <= '0;
         bus.out_syndrome  <= '0;
         bus.out_corrected <= 1'b0;
      end else if (accept) begin
         bus.out_valid     <= 1'b1;
         bus.out_data      <= {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};
         bus.out_syndrome  <= syndrome;
         bus.out_corrected <= (syndrome != 3'd0);
      end else if (bus.out_ready) begin
         bus.out_valid     <= 1'b0;
      end
   end

   // Saturating statistics; a clear drops any same-cycle increment.
   always_ff @(posedge clk) begin
      if (!rst_n || clr_count) begin
         word_count <= '0;
         corr_count <= '0;
      end else if (accept) begin
         if (word_count != CNT_MAX) begin
            word_count <= word_count + CNT_ONE;
         end
         if ((syndrome != 3'd0) && (corr_count != CNT_MAX)) begin
            corr_count <= corr_count + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_hamming74_decoder.sv
// -----------------------------------------------------------------------------
// tb_hamming74_decoder
//
// Directed bench for hamming74_decoder. The driver pushes the expected decode
// of each accepted codeword into a queue; an independent monitor pops and
// compares on every output handshake. A second instance with CNT_W = 4 sees
// the same stream to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_hamming74_decoder;

   typedef struct packed {
      logic [3:0] data;
      logic [2:0] syn;
      logic       corr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr_count;
   logic [15:0] word_count;
   logic [15:0] corr_count;
   logic [3:0]  word_count4;
   logic [3:0]  corr_count4;

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   hamming74_decoder_if bus  ();
   hamming74_decoder_if bus4 ();

   assign bus4.in_valid  = bus.in_valid;
   assign bus4.in_code   = bus.in_code;
   assign bus4.out_ready = bus.out_ready;

   hamming74_decoder #(.CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .clr_count  (clr_count),
      .word_count (word_count),
      .corr_count (corr_count)
   );

   hamming74_decoder #(.CNT_W(4)) dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus4),
      .clr_count  (clr_count),
      .word_count (word_count4),
      .corr_count (corr_count4)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference encoder, layout {d3,d2,d1,p4,d0,p2,p1}.
   function automatic logic [6:0] enc(input logic [3:0] d);
      logic p1, p2, p4;
      p1  = d[0] ^ d[1] ^ d[3];
      p2  = d[0] ^ d[2] ^ d[3];
      p4  = d[1] ^ d[2] ^ d[3];
      enc = {d[3], d[2], d[1], p4, d[0], p2, p1};
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one codeword until accepted; records the expected decode.
   task automatic send(input logic [6:0] code, input logic [3:0] d, input logic [2:0] s);
      bit done;
      done        = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_code  = code;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            exp_q.push_back('{data: d, syn: s, corr: (s != 3'd0)});
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) check("send_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
   endtask

   // Monitor: one output handshake per negedge that sees valid && ready.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_word", {24'd0, bus.out_data, bus.out_syndrome, bus.out_corrected},
                  {24'd0, mon_e});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] code;
      logic [6:0] w1;
      logic [3:0] base;
      int         base_cnt;

      rst_n         = 1'b0;
      clr_count     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_code   = '0;
      bus.out_ready = 1'b0;
      step(2);

      // Reset state
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_word", {bus.out_data, bus.out_syndrome, bus.out_corrected}, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_counts", {word_count, corr_count}, 0);
      rst_n = 1'b1;
      step(1);

      // Clean word, data-bit error, parity-bit error
      bus.out_ready = 1'b1;
      send(7'h55, 4'hB, 3'd0);
      check("clean_counts", {word_count, corr_count}, {16'd1, 16'd0});
      send(7'h45, 4'hB, 3'd5);
      check("dbit_counts", {word_count, corr_count}, {16'd2, 16'd1});
      send(7'h01, 4'h0, 3'd1);
      check("pbit_counts", {word_count, corr_count}, {16'd3, 16'd2});
      step(2);

      // Clear with no accept
      clr_count = 1'b1;
      step(1);
      clr_count = 1'b0;
      check("clr_counts", {word_count, corr_count}, 0);
      check("clr_counts4", {word_count4, corr_count4}, 0);

      // Exhaustive sweep: 16 data values x (no flip + 7 single flips)
      for (int d = 0; d < 16; d++) begin
         for (int e = 0; e < 8; e++) begin
            code = enc(4'(d));
            if (e != 0) code = code ^ (7'd1 << (e - 1));
            send(code, 4'(d), 3'(e));
         end
      end
      step(2);
      check("sweep_counts", {word_count, corr_count}, {16'd128, 16'd112});
      check("sat_counts4", {word_count4, corr_count4}, {4'd15, 4'd15});
      check("sweep_drained", exp_q.size(), 0);

      // Backpressure: hold a word while the next one waits
      base_cnt      = int'(word_count);
      bus.out_ready = 1'b0;
      w1            = 7'h45;
      send(w1, 4'hB, 3'd5);
      bus.in_valid = 1'b1;
      bus.in_code  = enc(4'h6);
      for (int i = 0; i < 5; i++) begin
         step(1);
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_hold", {bus.out_valid, bus.out_data, bus.out_syndrome, bus.out_corrected},
               {1'b1, 4'hB, 3'd5, 1'b1});
      end
      check("bp_word_count", word_count, 32'(base_cnt + 1));
      bus.out_ready = 1'b1;
      send(enc(4'h6), 4'h6, 3'd0);
      send(enc(4'h9) ^ 7'h40, 4'h9, 3'd7);
      send(enc(4'h3) ^ 7'h02, 4'h3, 3'd2);
      send(enc(4'hE), 4'hE, 3'd0);
      step(2);
      check("bp_drained", exp_q.size(), 0);
      check("bp_word_count_end", word_count, 32'(base_cnt + 5));

      // Clear coincident with an accept: counters still go to 0
      clr_count = 1'b1;
      send(7'h45, 4'hB, 3'd5);
      clr_count = 1'b0;
      check("clr_accept_counts", {word_count, corr_count}, 0);
      check("clr_accept_counts4", {word_count4, corr_count4}, 0);
      step(2);

      // Saturation from zero with CNT_W = 4: 20 accepts hold at 15
      for (int i = 0; i < 20; i++) begin
         base = 4'(i);
         send(enc(base), base, 3'd0);
      end
      step(2);
      check("sat20_counts4", {word_count4, corr_count4}, {4'd15, 4'd0});
      check("sat20_counts", word_count, 20);

      // Reset mid-stream while a word is held
      bus.out_ready = 1'b0;
      send(7'h55, 4'hB, 3'd0);
      check("pre_rst_valid", bus.out_valid, 1);
      void'(exp_q.pop_back());
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      check("mid_rst_outputs", {bus.out_valid, bus.out_data, bus.out_syndrome, bus.out_corrected}, 0);
      check("mid_rst_in_ready", bus.in_ready, 1);
      check("mid_rst_counts", {word_count, corr_count}, 0);
      bus.out_ready = 1'b1;
      step(4);
      check("mid_rst_no_emit", bus.out_valid, 0);
      check("final_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hamming74_decoder.md
# hamming74_decoder

Streaming Hamming(7,4) single-error-correcting decoder. It consumes 7-bit codewords in the encoder's bit layout and computes the 3-bit syndrome. It corrects any single-bit error and returns the 4 data bits through a registered valid/ready output stage. It sits directly downstream of the 7-bit encoder on the channel/receive side and keeps saturating statistics counters for link monitoring.

## Interface
- CNT_W, 16, width of the statistics counters (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream codeword valid
- in_ready  output  1  decoder can accept a codeword this cycle
- in_code  input  7  codeword, bit0=p1, bit1=p2, bit2=d0, bit3=p4, bit4=d1, bit5=d2, bit6=d3
- out_valid  output  1  decoded word held in output register
- out_ready  input  1  downstream accepts output this cycle
- out_data  output  4  corrected data {d3,d2,d1,d0}
- out_syndrome  output  3  syndrome {s4,s2,s1}; 0 = no error, else 1-based bit position of the error
- out_corrected  output  1  syndrome was non-zero (one bit flipped)
- clr_count  input  1  synchronous clear of both counters
- word_count  output  CNT_W  codewords accepted since reset/clear, saturating
- corr_count  output  CNT_W  codewords with non-zero syndrome, saturating

## Operation
- Syndrome: s1 = c0^c2^c4^c6, s2 = c1^c2^c5^c6, s4 = c3^c4^c5^c6.
- Correction: for non-zero syndrome S, invert codeword bit S-1, then extract d0=c2, d1=c4, d2=c5, d3=c6.
- A flipped parity bit (S = 1, 2 or 4) leaves the data unchanged but still sets out_corrected.
- Double errors are miscorrected silently. This is inherent to (7,4) and out of scope.
- Output stage is a single register with flow control: in_ready = !out_valid || out_ready (combinational, no skid buffer).
- Accept event: in_valid && in_ready. On accept:
  - Load out_data, out_syndrome and out_corrected.
  - Set out_valid = 1.
  - Increment word_count.
  - Increment corr_count if the syndrome is non-zero.
- Output event: out_valid && out_ready with no simultaneous accept clears out_valid. An output event with a simultaneous accept reloads the register, and out_valid stays 1.
- While out_valid && !out_ready, out_data, out_syndrome and out_corrected hold stable. in_code is ignored.
- Counters:
  - Saturate at 2^CNT_W-1 and do not wrap.
  - clr_count has priority: the counters go to 0 and any increment in the same cycle is dropped.
  - clr_count does not affect the data path.

## Timing
- Reset (rst_n = 0 at a clk edge):
  - out_valid = 0, out_data = 0, out_syndrome = 0, out_corrected = 0.
  - word_count = 0, corr_count = 0.
  - in_ready reads 1 after reset because out_valid = 0.
- Reset mid-operation discards the held word with no output handshake. Counters clear.
- Latency: 1 cycle. A codeword accepted at edge N is presented with out_valid = 1 after edge N.
- Throughput: 1 word/cycle while out_ready = 1.
- Counters update on the same edge as the accept. Their values are visible the cycle after.
- No combinational path from in_code to any output. The only combinational path is out_ready -> in_ready.

## Test plan
- Clean word: in_code = 7'h55 (data 4'b1011), out_ready = 1 -> next cycle:
  - out_data = 4'hB, out_syndrome = 0, out_corrected = 0.
  - word_count = 1, corr_count = 0.
- Data-bit error: in_code = 7'h45 (bit4 flipped from 7'h55) -> out_data = 4'hB, out_syndrome = 3'd5, out_corrected = 1, corr_count increments by 1.
- Parity-bit error plus exhaustive sweep:
  - in_code = 7'h01 -> out_data = 0, out_syndrome = 1, out_corrected = 1.
  - Sweep all 16 data values × 8 error patterns (none, each of the 7 single-bit flips). Every out_data equals the original data, and every syndrome equals the flip position or 0.
  - Final word_count = 128 and corr_count = 112.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles with in_valid = 1 -> out_* stable, in_ready = 0, word_count advances by only 1.
  - Release out_ready -> back-to-back words drain at 1/cycle, with no loss or duplication against the scoreboard.
- Counter edge cases:
  - Force word_count to saturate (CNT_W = 4, 20 accepts) -> holds at 15.
  - Assert clr_count on the same cycle as an accept -> both counters read 0 next cycle.
- Reset mid-stream: drop rst_n for 1 cycle while out_valid = 1 and out_ready = 0 -> all outputs and counters are 0 next cycle, in_ready = 1, and the held word is never emitted.
